// File: rtl/mult18_arbiter_if.sv
// Requester-side bus of mult18_arbiter: packed 18-bit operand pairs in, one-hot ready out,
// and a one-cycle tagged 36-bit response back to the requesters.
interface mult18_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]      req_valid;
  logic [18*NREQ-1:0]   req_a;
  logic [18*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic [ID_W-1:0]      rsp_id;
  logic [35:0]          rsp_p;
  logic                 rsp_err;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_id, rsp_p, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_id, rsp_p, rsp_err
  );
endinterface

// File: rtl/mult18_arbiter.sv
// Round-robin arbiter sharing one mult18 among NREQ requesters via its level start/done handshake.
// Optional ISSUE watchdog is built only when MULT18_ARB_WDOG_EN is defined.
module mult18_arbiter #(
  parameter int NREQ        = 4,
  parameter int WDOG_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  mult18_arbiter_if.slave       arb,
  output logic                  m_start_o,
  output logic [17:0]           m_a_o,
  output logic [17:0]           m_b_o,
  input  logic                  m_done_i,
  input  logic [35:0]           m_p_i
);
  localparam int ID_W = $clog2(NREQ);
  localparam int OP_W = 18;
  localparam int P_W  = 36;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RELEASE
  } state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_last_q, rr_last_d;
  logic [ID_W-1:0] cur_id_q, cur_id_d;
  logic            m_start_q, m_start_d;
  logic [OP_W-1:0] m_a_q, m_a_d;
  logic [OP_W-1:0] m_b_q, m_b_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [P_W-1:0]  rsp_p_q, rsp_p_d;

`ifdef MULT18_ARB_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              rsp_err_q, rsp_err_d;
`endif

  logic            any_valid;
  logic [ID_W-1:0] winner;
  logic [NREQ-1:0] ready_c;

  // Scan upward from the requester after the last winner, wrapping modulo NREQ.
  always_comb begin : rr_pick
    logic [ID_W-1:0] cand;
    int              sum;
    // NOTE: every variable driven here gets a value before any branch, so no latch is inferred.
    any_valid = 1'b0;
    winner    = '0;
    cand      = '0;
    sum       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = int'(rr_last_q) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      cand = ID_W'(sum);
      if (!any_valid && arb.req_valid[cand]) begin
        any_valid = 1'b1;
        winner    = cand;
      end
    end
  end

  always_comb begin : fsm_next
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    cur_id_d    = cur_id_q;
    m_start_d   = m_start_q;
    m_a_d       = m_a_q;
    m_b_d       = m_b_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_p_d     = rsp_p_q;
    ready_c     = '0;
`ifdef MULT18_ARB_WDOG_EN
    wdog_d      = wdog_q;
    rsp_err_d   = rsp_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          ready_c[winner] = 1'b1;
          m_a_d           = arb.req_a[OP_W*winner +: OP_W];
          m_b_d           = arb.req_b[OP_W*winner +: OP_W];
          cur_id_d        = winner;
          rr_last_d       = winner;
          m_start_d       = 1'b1;
          state_d         = ST_ISSUE;
`ifdef MULT18_ARB_WDOG_EN
          wdog_d          = '0;
`endif
        end
      end

      ST_ISSUE: begin
        if (m_done_i) begin
          rsp_p_d     = m_p_i;
          rsp_id_d    = cur_id_q;
          rsp_valid_d = 1'b1;
          m_start_d   = 1'b0;
          state_d     = ST_RELEASE;
`ifdef MULT18_ARB_WDOG_EN
          rsp_err_d   = 1'b0;
`endif
        end
`ifdef MULT18_ARB_WDOG_EN
        // Timeout fires on the edge that closes the WDOG_CYCLES-th cycle spent in ISSUE.
        else if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
          rsp_p_d     = '0;
          rsp_id_d    = cur_id_q;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          m_start_d   = 1'b0;
          state_d     = ST_RELEASE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end

      ST_RELEASE: begin
        if (!m_done_i) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_last_q   <= ID_W'(NREQ - 1);
      cur_id_q    <= '0;
      m_start_q   <= 1'b0;
      m_a_q       <= '0;
      m_b_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_p_q     <= '0;
`ifdef MULT18_ARB_WDOG_EN
      wdog_q      <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      cur_id_q    <= cur_id_d;
      m_start_q   <= m_start_d;
      m_a_q       <= m_a_d;
      m_b_q       <= m_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_p_q     <= rsp_p_d;
`ifdef MULT18_ARB_WDOG_EN
      wdog_q      <= wdog_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  // Ready is combinational from req_valid, so it is forced low while reset is held.
  assign arb.req_ready = rst ? '0 : ready_c;
  assign arb.rsp_valid = rsp_valid_q;
  assign arb.rsp_id    = rsp_id_q;
  assign arb.rsp_p     = rsp_p_q;
`ifdef MULT18_ARB_WDOG_EN
  assign arb.rsp_err   = rsp_err_q;
`else
  assign arb.rsp_err   = 1'b0;
`endif

  assign m_start_o = m_start_q;
  assign m_a_o     = m_a_q;
  assign m_b_o     = m_b_q;
endmodule

// File: tb/tb_mult18_arbiter.sv
// Self-checking bench for mult18_arbiter: directed test-plan steps plus randomized traffic
// against a cycle-timing reference model and a behavioural mult18 stub.
module tb_mult18_arbiter;
  localparam int NREQ  = 4;
  localparam int WDOG  = 15;
  localparam int ID_W  = $clog2(NREQ);
  localparam int NEVER = 32'h7fff_ffff;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_start, m_done;
  logic [17:0] m_a, m_b;
  logic [35:0] m_p;

  int n_checks = 0;
  int n_errors = 0;
  int stub_lat = 0;
  bit stub_hang = 1'b0;

  mult18_arbiter_if #(.NREQ(NREQ)) arb ();

  mult18_arbiter #(.NREQ(NREQ), .WDOG_CYCLES(WDOG)) dut (
    .clk       (clk),
    .rst       (rst),
    .arb       (arb),
    .m_start_o (m_start),
    .m_a_o     (m_a),
    .m_b_o     (m_b),
    .m_done_i  (m_done),
    .m_p_i     (m_p)
  );

  always #5 clk = ~clk;

  // mult18 stub: done rises stub_lat cycles after start is seen, falls one cycle after start drops.
  int stub_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_done   <= 1'b0;
      stub_cnt <= 0;
    end else begin
      stub_cnt <= (!m_start || m_done) ? 0 : stub_cnt + 1;
      m_done   <= m_start && !stub_hang && (stub_cnt >= stub_lat);
    end
  end
  assign m_p = {18'd0, m_a} * {18'd0, m_b};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: sampled mid-cycle, derives ready/start/response timing from the
  // protocol figures (accept at T0, start T1.., response T3+lat, next accept T5+lat).
  typedef struct {
    int          due;
    int          id;
    logic [35:0] p;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   free_at = 0;
  int   last = NREQ - 1;
  int   iss_lo = 0;
  int   iss_hi = -1;

  always @(negedge clk) begin : model
    logic [NREQ-1:0] exp_ready;
    int              win;
    int              idx;
    exp_t            e;
    exp_ready = '0;
    win       = -1;
    idx       = 0;
    if (rst) begin
      exp_q.delete();
      free_at = 0;
      last    = NREQ - 1;
      iss_lo  = 0;
      iss_hi  = -1;
      check("model_rst_ready", arb.req_ready, '0);
      check("model_rst_rsp_valid", arb.rsp_valid, 0);
      check("model_rst_m_start", m_start, 0);
    end else begin
      if (cyc >= free_at) begin
        for (int k = 1; k <= NREQ; k++) begin
          idx = (last + k) % NREQ;
          if (win < 0 && arb.req_valid[idx]) win = idx;
        end
      end
      if (win >= 0) exp_ready[win] = 1'b1;
      check("model_ready", arb.req_ready, exp_ready);
      check("model_m_start", m_start, (cyc >= iss_lo && cyc <= iss_hi));
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        check("model_rsp_valid", arb.rsp_valid, 1);
        check("model_rsp_id", arb.rsp_id, e.id);
        check("model_rsp_p", arb.rsp_p, e.p);
        check("model_rsp_err", arb.rsp_err, e.err);
      end else begin
        check("model_rsp_quiet", arb.rsp_valid, 0);
      end
      if (win >= 0) begin
        last   = win;
        e.id   = win;
        iss_lo = cyc + 1;
        if (!stub_hang) begin
          e.due   = cyc + 3 + stub_lat;
          e.p     = 36'(arb.req_a[18*win +: 18]) * 36'(arb.req_b[18*win +: 18]);
          e.err   = 1'b0;
          exp_q.push_back(e);
          free_at = cyc + 5 + stub_lat;
          iss_hi  = cyc + 2 + stub_lat;
        end else begin
`ifdef MULT18_ARB_WDOG_EN
          e.due   = cyc + 1 + WDOG;
          e.p     = '0;
          e.err   = 1'b1;
          exp_q.push_back(e);
          free_at = cyc + 2 + WDOG;
          iss_hi  = cyc + WDOG;
`else
          free_at = NEVER;
          iss_hi  = NEVER;
`endif
        end
      end
    end
    cyc++;
  end

  // NOTE: stimulus is driven with blocking assignments 1 time unit after the active edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] rand18();
    case ($urandom_range(0, 7))
      0:       return 18'h00000;
      1:       return 18'h3FFFF;
      default: return 18'($urandom);
    endcase
  endfunction

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ready"}, arb.req_ready, '0);
    check({tag, "_rsp_valid"}, arb.rsp_valid, 0);
    check({tag, "_rsp_id"}, arb.rsp_id, 0);
    check({tag, "_rsp_p"}, arb.rsp_p, 0);
    check({tag, "_rsp_err"}, arb.rsp_err, 0);
    check({tag, "_m_start"}, m_start, 0);
    check({tag, "_m_a"}, m_a, 0);
    check({tag, "_m_b"}, m_b, 0);
  endtask

  // One isolated request, checked cycle by cycle from T0 to T4.
  task automatic single(input string tag, input int id, input logic [17:0] a,
                        input logic [17:0] b, input logic [35:0] exp_p);
    logic [NREQ-1:0] onehot;
    onehot = '0;
    onehot[id] = 1'b1;
    arb.req_a[18*id +: 18] = a;
    arb.req_b[18*id +: 18] = b;
    arb.req_valid = onehot;
    @(negedge clk);
    check({tag, "_T0_ready"}, arb.req_ready, onehot);
    next_cycle();
    arb.req_valid = '0;
    arb.req_a[18*id +: 18] = ~a;
    @(negedge clk);
    check({tag, "_T1_m_start"}, m_start, 1);
    check({tag, "_T1_m_a"}, m_a, a);
    check({tag, "_T1_m_b"}, m_b, b);
    next_cycle();
    @(negedge clk);
    check({tag, "_T2_rsp_valid"}, arb.rsp_valid, 0);
    next_cycle();
    @(negedge clk);
    check({tag, "_T3_rsp_valid"}, arb.rsp_valid, 1);
    check({tag, "_T3_rsp_id"}, arb.rsp_id, id);
    check({tag, "_T3_rsp_p"}, arb.rsp_p, exp_p);
    check({tag, "_T3_rsp_err"}, arb.rsp_err, 0);
    check({tag, "_T3_m_start"}, m_start, 0);
    next_cycle();
    @(negedge clk);
    check({tag, "_T4_rsp_valid"}, arb.rsp_valid, 0);
    next_cycle();
  endtask

  initial begin : stimulus
    int acc_id[6];
    int acc_cyc[6];
    int n_acc;
    int n_rsp;
    int n_bad;
    int lat;
    bit found;

    rst = 1'b1;
    arb.req_valid = '1;
    arb.req_a = '0;
    arb.req_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    next_cycle();
    rst = 1'b0;
    arb.req_valid = '0;
    next_cycle();

    single("single", 1, 18'd3, 18'd5, 36'd15);
    single("max", 2, 18'h3FFFF, 18'h3FFFF, 36'hFFFF80001);
    single("zero", 3, 18'd0, 18'h12345, 36'd0);

    // Fairness: everyone valid, expect 0,1,2,3,0,1 at 5-cycle spacing.
    for (int i = 0; i < NREQ; i++) begin
      arb.req_a[18*i +: 18] = rand18();
      arb.req_b[18*i +: 18] = rand18();
    end
    arb.req_valid = '1;
    n_acc = 0;
    for (int t = 0; t < 80 && n_acc < 6; t++) begin
      @(negedge clk);
      check("fair_onehot0", $onehot0(arb.req_ready), 1);
      if (arb.req_ready != '0) begin
        for (int i = 0; i < NREQ; i++) if (arb.req_ready[i]) acc_id[n_acc] = i;
        acc_cyc[n_acc] = t;
        n_acc++;
      end
      next_cycle();
    end
    arb.req_valid = '0;
    check("fair_count", n_acc, 6);
    for (int i = 0; i < n_acc; i++) begin
      check("fair_order", acc_id[i], i % NREQ);
      if (i > 0) check("fair_spacing", acc_cyc[i] - acc_cyc[i-1], 5);
    end
    repeat (8) next_cycle();

    // Withdrawn: requester 3 pulses valid for one cycle while the FSM is in ISSUE.
    arb.req_a[17:0] = rand18();
    arb.req_b[17:0] = rand18();
    arb.req_valid = 4'b0001;
    @(negedge clk);
    check("wd_T0_ready", arb.req_ready, 4'b0001);
    next_cycle();
    arb.req_valid = 4'b1000;
    @(negedge clk);
    check("wd_T1_ready", arb.req_ready, '0);
    next_cycle();
    arb.req_valid = '0;
    n_rsp = 0;
    n_bad = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (arb.rsp_valid) begin
        n_rsp++;
        if (arb.rsp_id == ID_W'(3)) n_bad++;
      end
      next_cycle();
    end
    check("wd_rsp_count", n_rsp, 1);
    check("wd_rsp_id3", n_bad, 0);

    // Reset at T2 aborts requester 2; afterwards requester 0 beats requester 1.
    arb.req_a[18*2 +: 18] = rand18();
    arb.req_b[18*2 +: 18] = rand18();
    arb.req_valid = 4'b0100;
    @(negedge clk);
    check("rmid_T0_ready", arb.req_ready, 4'b0100);
    next_cycle();
    arb.req_valid = '0;
    next_cycle();
    rst = 1'b1;
    arb.req_valid = 4'b0011;
    @(negedge clk);
    check_zero_outputs("rmid");
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rmid_first_ready", arb.req_ready, 4'b0001);
    next_cycle();
    arb.req_valid = '0;
    n_rsp = 0;
    n_bad = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (arb.rsp_valid) begin
        if (arb.rsp_id == ID_W'(0)) n_rsp++;
        else n_bad++;
      end
      next_cycle();
    end
    check("rmid_rsp_id0", n_rsp, 1);
    check("rmid_rsp_other", n_bad, 0);

    // Randomized traffic, including withdrawals, at two multiplier latencies.
    for (int ph = 0; ph < 2; ph++) begin
      stub_lat = ph * 2;
      for (int t = 0; t < 300; t++) begin
        arb.req_valid = NREQ'($urandom);
        for (int i = 0; i < NREQ; i++) begin
          arb.req_a[18*i +: 18] = rand18();
          arb.req_b[18*i +: 18] = rand18();
        end
        next_cycle();
      end
      arb.req_valid = '0;
      repeat (12) next_cycle();
    end
    stub_lat = 0;

    // Multiplier that never answers.
    stub_hang = 1'b1;
    arb.req_a[18*1 +: 18] = rand18();
    arb.req_b[18*1 +: 18] = rand18();
    arb.req_valid = 4'b0010;
    @(negedge clk);
    check("hang_T0_ready", arb.req_ready, 4'b0010);
    next_cycle();
    arb.req_valid = '0;
`ifdef MULT18_ARB_WDOG_EN
    found = 1'b0;
    lat = 0;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (!found && arb.rsp_valid) begin
        found = 1'b1;
        lat = t;
        check("wdog_rsp_err", arb.rsp_err, 1);
        check("wdog_rsp_p", arb.rsp_p, 0);
        check("wdog_rsp_id", arb.rsp_id, 1);
      end
      next_cycle();
    end
    check("wdog_found", found, 1);
    check("wdog_latency", lat, WDOG + 1);
    stub_hang = 1'b0;
`else
    found = 1'b0;
    lat = 0;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (arb.rsp_valid) found = 1'b1;
      next_cycle();
    end
    @(negedge clk);
    check("hang_no_rsp", found, 0);
    check("hang_m_start_held", m_start, 1);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    stub_hang = 1'b0;
`endif
    repeat (4) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog_timer
    #200000;
    $display("FAIL timeout: simulation did not complete, observed no finish expected finish");
    $fatal(1, "tb_mult18_arbiter timeout");
  end
endmodule

// File: doc/mult18_arbiter.md
# mult18_arbiter

Round-robin arbiter and sequencer that shares a single `mult18` instance among `NREQ` requesters inside the Karatsuba multiplier tree. It accepts one 18×18 operand pair at a time and drives the `mult18` level-sensitive start/done handshake: start held until done, then dropped until done clears. It returns each 36-bit product to the winning requester as a one-cycle response tagged with the requester index.

## Interface
- `NREQ`, default 4: number of requesters, ≥2.
- `WDOG_CYCLES`, default 15: watchdog limit in cycles. Used only with `MULT18_ARB_WDOG_EN`.
- Reset `rst`, asynchronous, active-high; clock `clk`.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-high reset.
- `req_valid`  in  NREQ  request per requester. Held with stable operands until `req_ready[i]`.
- `req_a`  in  18*NREQ  operand A; requester i occupies bits [18*i+17:18*i].
- `req_b`  in  18*NREQ  operand B; same packing as `req_a`.
- `req_ready`  out  NREQ  one-hot acceptance. Transfer occurs on a clock edge with `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_id`  out  $clog2(NREQ)  index of the requester being answered.
- `rsp_p`  out  36  product.
- `rsp_err`  out  1  watchdog abort flag. Constant 0 when the watchdog is compiled out.
- `m_start`  out  1  to `mult18` start.
- `m_a`, `m_b`  out  18  to `mult18` A and B.
- `m_done`  in  1  from `mult18` done.
- `m_p`  in  36  from `mult18` P.

## Operation
- The FSM has three states: IDLE, ISSUE and RELEASE.
- **IDLE**
  - If any `req_valid` is set, the winner is the first asserted index scanning upward from `rr_last+1` mod NREQ.
  - `req_ready[winner]` is driven combinationally in IDLE only.
  - At the edge: register `m_a`/`m_b` from the winner's operands, set `cur_id=winner`, set `rr_last=winner`, set `m_start<=1`, and go to ISSUE.
- **ISSUE**
  - `m_start=1` and operands are held stable.
  - When `m_done==1`:
    - `rsp_p<=m_p`, `rsp_id<=cur_id`, `rsp_valid<=1`, `rsp_err<=0`
    - `m_start<=0`
    - go to RELEASE.
- **RELEASE**
  - `m_start=0`.
  - When `m_done==0`, go to IDLE.
- `rsp_valid` is high for exactly one cycle per accepted request.
- `req_ready` is all-zero outside IDLE.
- Operands are captured at acceptance, so a requester may change them afterwards.
- A requester that deasserts `req_valid` before being accepted is simply not served. No state changes.
- Arithmetic is unsigned: product = A*B, 36 bits, no truncation. The arbiter never modifies `m_p`.
- Reset values:
  - state IDLE, `rr_last=NREQ-1` (requester 0 has first priority)
  - `m_start=0`, `m_a=m_b=0`
  - `rsp_valid=0`, `rsp_id=0`, `rsp_p=0`, `rsp_err=0`
  - `req_ready=0`
- Reset mid-operation aborts the operation with no response. The `mult18` shares `rst`, so it is reset in the same way.

## Timing
Cycle numbering starts at T0, the acceptance cycle:
- T0: IDLE, `req_ready` high, transfer at the edge.
- T1: ISSUE, `m_start=1`.
- T2: `m_done=1`; product captured at the edge.
- T3: RELEASE, `rsp_valid=1`, `m_start=0`, `m_done` still 1.
- T4: `m_done=0`.
- T5: IDLE, next acceptance possible.

Derived figures:
- Latency from acceptance edge to `rsp_valid` is 3 cycles.
- Minimum acceptance spacing is 5 cycles.
- A requester may re-request while its own response is pending. It is arbitrated normally in the next IDLE.

## Configuration
- `MULT18_ARB_WDOG_EN` defined:
  - A counter runs while in ISSUE.
  - If `WDOG_CYCLES` cycles elapse without `m_done`, the block sets `m_start<=0`, emits `rsp_valid=1` with `rsp_err=1`, `rsp_p=0`, `rsp_id=cur_id`, and goes to RELEASE.
  - The counter clears on entering ISSUE.
- `MULT18_ARB_WDOG_EN` undefined:
  - No counter is built; `rsp_err` is tied 0.
  - ISSUE waits indefinitely for `m_done`.

## Test plan
- **Single request:** `req_valid[1]`, A=3, B=5 at T0 → `rsp_valid` at T3, `rsp_id=1`, `rsp_p=36'd15`, `rsp_err=0`.
- **Maximum operands:** A=B=18'h3FFFF on requester 2 → `rsp_p=36'hFFFF80001`. Zero operand A=0, B=18'h12345 → `rsp_p=0`.
- **Round-robin fairness:** all four requesters valid continuously → acceptances in order 0,1,2,3,0,1, spaced exactly 5 cycles apart. `req_ready` is one-hot and only in IDLE.
- **Withdrawn request:** `req_valid[3]` pulsed for one cycle while the FSM is in ISSUE → never accepted, no response for id 3.
- **Reset mid-operation:** assert `rst` at T2 → all outputs 0 immediately, no `rsp_valid`. After release with requesters 1 and 0 valid, requester 0 is accepted first.
- **Watchdog:** with `MULT18_ARB_WDOG_EN`, `WDOG_CYCLES=15`, and a stub holding `m_done=0` → 15 cycles in ISSUE, then `rsp_valid=1`, `rsp_err=1`, `rsp_p=0`, then IDLE. With the macro undefined → remains in ISSUE, `rsp_valid` never asserts.
